// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants for the multiplexed 7-segment driver.
//   SEG_HEX_0..SEG_HEX_F : active-low g..a patterns for each hex value
//   SEG_ALL_OFF          : all seven segments dark (dp excluded)
//   SEG_BLANK            : full cathode byte with every segment and dp dark
//   an_off()             : level of one active-low anode line
package seg7_pkg;

    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

    localparam logic [6:0] SEG_ALL_OFF = 7'h7F;
    localparam logic [7:0] SEG_BLANK   = 8'hFF;

    // Returns 1 (anode off) unless this anode is the selected digit and the
    // display is not being forced dark.
    function automatic logic an_off(input logic dark, input logic selected);
        return dark | ~selected;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode
// Combinational hex nibble to active-low 7-segment pattern.
//   i_nibble : value 0..F
//   o_seg    : segments g..a, active-low
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_HEX_0;
        case (i_nibble)
            4'h0: o_seg = SEG_HEX_0;
            4'h1: o_seg = SEG_HEX_1;
            4'h2: o_seg = SEG_HEX_2;
            4'h3: o_seg = SEG_HEX_3;
            4'h4: o_seg = SEG_HEX_4;
            4'h5: o_seg = SEG_HEX_5;
            4'h6: o_seg = SEG_HEX_6;
            4'h7: o_seg = SEG_HEX_7;
            4'h8: o_seg = SEG_HEX_8;
            4'h9: o_seg = SEG_HEX_9;
            4'hA: o_seg = SEG_HEX_A;
            4'hB: o_seg = SEG_HEX_B;
            4'hC: o_seg = SEG_HEX_C;
            4'hD: o_seg = SEG_HEX_D;
            4'hE: o_seg = SEG_HEX_E;
            4'hF: o_seg = SEG_HEX_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
// Scans leftmost digit first, one digit per SCAN_DIV clocks, with hex decode,
// per-digit dp, per-digit blink, leading-zero blanking and a guard interval.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   en          : 1 = display on, 0 = anodes dark (scan keeps running)
//   digits      : nibble i = digits[4i+3:4i], digit 0 rightmost
//   dp          : decimal point request per digit (1 = lit)
//   blink_mask  : 1 = digit dark during the off blink phase
//   blank_lz    : 1 = suppress leading zeros (digit 0 never suppressed)
//   an          : anodes, active-low, an[i] drives digit i
//   seg         : cathodes, active-low, seg[7] = dp, seg[6:0] = g..a
//   frame_tick  : one-cycle pulse when the last slot of a frame ends
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 0,
    parameter int BLINK_FRAMES = 62
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg,
    output logic                    frame_tick
);

    localparam int CW = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int IW = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [CW-1:0]         r_slot_cnt;
    logic [IW-1:0]         r_idx;
    logic                  r_frame_tick;
    logic [BW-1:0]         r_blink_cnt;
    logic                  r_blink_phase;
    logic [NUM_DIGITS-1:0] r_an;
    logic [7:0]            r_seg;

    logic                  w_slot_tick;
    logic [3:0]            w_nibble;
    logic                  w_dp_sel;
    logic                  w_blink_sel;
    logic                  w_run;
    logic                  w_upper_zero;
    logic                  w_lz_blank;
    logic                  w_dark;
    logic [6:0]            w_hex;
    logic [NUM_DIGITS-1:0] w_an_next;
    logic                  w_in_guard;

    assign w_slot_tick = (r_slot_cnt == SLOT_LAST);

    // Slot prescaler, digit index and registered frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt   <= '0;
            r_idx        <= IDX_LAST;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_slot_tick && (r_idx == '0);
            if (w_slot_tick) begin
                r_slot_cnt <= '0;
                r_idx      <= (r_idx == '0) ? IDX_LAST : r_idx - IW'(1);
            end else begin
                r_slot_cnt <= r_slot_cnt + CW'(1);
            end
        end
    end

    // Blink phase flips every BLINK_FRAMES completed frames; 0 = visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_frame_tick) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

    // Select the inputs for digit r_idx, which is loaded at the coming slot
    // boundary. Walking from the leftmost digit down, w_run stays high while
    // every nibble seen so far is zero, giving the leading-zero condition.
    always_comb begin
        w_nibble     = 4'h0;
        w_dp_sel     = 1'b0;
        w_blink_sel  = 1'b0;
        w_run        = 1'b1;
        w_upper_zero = 1'b0;
        for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
            w_run = w_run & (digits[4*j +: 4] == 4'h0);
            if (r_idx == IW'(j)) begin
                w_nibble     = digits[4*j +: 4];
                w_dp_sel     = dp[j];
                w_blink_sel  = blink_mask[j];
                w_upper_zero = w_run;
            end
        end
    end

    assign w_lz_blank = blank_lz && (r_idx != '0) && w_upper_zero;
    assign w_dark     = !en || (w_blink_sel && r_blink_phase);

    always_comb begin
        w_an_next = '1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            w_an_next[j] = an_off(w_dark, r_idx == IW'(j));
        end
    end

    seg7_hex_decode u_hex_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_hex)
    );

    // Display register: loaded only at slot boundaries so mid-slot input
    // changes never glitch the digit being shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
        end else if (w_slot_tick) begin
            r_an  <= w_an_next;
            r_seg <= {~w_dp_sel, w_lz_blank ? SEG_ALL_OFF : w_hex};
        end
    end

    // Anti-ghosting: anodes stay dark for the first GUARD clocks of a slot
    // while the cathodes already carry the new digit.
    generate
        if (GUARD > 0) begin : g_guard
            assign w_in_guard = (r_slot_cnt < CW'(GUARD));
        end else begin : g_no_guard
            assign w_in_guard = 1'b0;
        end
    endgenerate

    assign an         = w_in_guard ? '1 : r_an;
    assign seg        = r_seg;
    assign frame_tick = r_frame_tick;

endmodule
